isolation_tree_detector: RTL

ISOLATION_TREE_DETECTOR -- requirements
Module: isolation_tree_detector

---
 rtl/itree_pkg.sv | 41 ++++
 rtl/itree_node_mem.sv | 60 ++++++
 rtl/isolation_tree_detector.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/itree_pkg.sv
// Shared types and width helpers for the isolation-tree anomaly detector.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
// Contents: FSM state enum, node-record field-width helpers, default
// parameter constants, and the node record layout for default parameters.
package itree_pkg;

  localparam int ITREE_DATA_W_DFLT   = 8;
  localparam int ITREE_NUM_FEAT_DFLT = 4;
  localparam int ITREE_DEPTH_DFLT    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WALK = 2'd1,
    ST_DONE = 2'd2
  } itree_state_t;

  // Feature-index field width; at least one bit so a single-feature tree
  // still has a field that can mark a node as an out-of-range stop.
  function automatic int itree_feat_w(input int num_feat);
    return (num_feat > 1) ? $clog2(num_feat) : 1;
  endfunction

  // Path-length width: must hold 0..depth inclusive.
  function automatic int itree_len_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Number of nodes in a full binary tree of the given comparison depth.
  function automatic int itree_nodes(input int depth);
    return (1 << depth) - 1;
  endfunction

  // Node record layout at default parameters: {feat, thr, leaf}.
  typedef struct packed {
    logic [1:0] feat;
    logic [7:0] thr;
    logic       leaf;
  } itree_node_dflt_t;

endpackage

// File: rtl/itree_node_mem.sv
// Node table: 2^DEPTH-1 {feat, thr, leaf} records held in flops.
// Latency: write lands on the next rising clk; read is combinational.
// Backpressure: none; writes to addresses past the last node are dropped.
// Ports: clk, reset (sync active-low, clears every node to a zero leaf);
//   wr_en/wr_addr/wr_feat/wr_thr/wr_leaf write port;
//   rd_addr -> rd_feat/rd_thr/rd_leaf read port.
module itree_node_mem
  import itree_pkg::*;
#(
  parameter int DATA_W   = ITREE_DATA_W_DFLT,
  parameter int NUM_FEAT = ITREE_NUM_FEAT_DFLT,
  parameter int DEPTH    = ITREE_DEPTH_DFLT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                wr_en,
  input  logic [DEPTH-1:0]                    wr_addr,
  input  logic [itree_feat_w(NUM_FEAT)-1:0]   wr_feat,
  input  logic [DATA_W-1:0]                   wr_thr,
  input  logic                                wr_leaf,
  input  logic [DEPTH-1:0]                    rd_addr,
  output logic [itree_feat_w(NUM_FEAT)-1:0]   rd_feat,
  output logic [DATA_W-1:0]                   rd_thr,
  output logic                                rd_leaf
);

  localparam int FEAT_W = itree_feat_w(NUM_FEAT);
  localparam int NODES  = itree_nodes(DEPTH);

  typedef struct packed {
    logic [FEAT_W-1:0] feat;
    logic [DATA_W-1:0] thr;
    logic              leaf;
  } node_t;

  node_t node_q [NODES];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NODES; i++) begin
        node_q[i] <= '{feat: '0, thr: '0, leaf: 1'b1};
      end
    end else if (wr_en && (int'(wr_addr) < NODES)) begin
      node_q[wr_addr] <= '{feat: wr_feat, thr: wr_thr, leaf: wr_leaf};
    end
  end

  // The all-ones address has no node behind it; present it as a leaf.
  always_comb begin
    rd_feat = '0;
    rd_thr  = '0;
    rd_leaf = 1'b1;
    if (int'(rd_addr) < NODES) begin
      rd_feat = node_q[rd_addr].feat;
      rd_thr  = node_q[rd_addr].thr;
      rd_leaf = node_q[rd_addr].leaf;
    end
  end

endmodule

// File: rtl/isolation_tree_detector.sv
// Isolation-tree anomaly scorer: walks one sample down a configurable tree.
// Latency: out_valid DEPTH-bounded, W+1 cycles after accept (W = walk cycles).
// Backpressure: one sample in flight; results hold until out_ready, in_ready only in IDLE.
// Ports: clk, reset (sync active-low); in_valid/in_ready/in_data + anom_len
//   sample input; out_valid/out_ready/out_anomaly/out_path_len result;
//   cfg_we/cfg_addr/cfg_feat/cfg_thr/cfg_leaf node-table write (IDLE only).
// Option: define ITREE_STATS_EN to add the 16-bit saturating anom_count output.
module isolation_tree_detector
  import itree_pkg::*;
#(
  parameter int DATA_W   = ITREE_DATA_W_DFLT,
  parameter int NUM_FEAT = ITREE_NUM_FEAT_DFLT,
  parameter int DEPTH    = ITREE_DEPTH_DFLT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_FEAT*DATA_W-1:0]          in_data,
  input  logic [$clog2(DEPTH+1)-1:0]          anom_len,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_anomaly,
  output logic [$clog2(DEPTH+1)-1:0]          out_path_len,
`ifdef ITREE_STATS_EN
  output logic [15:0]                         anom_count,
`endif
  input  logic                                cfg_we,
  input  logic [DEPTH-1:0]                    cfg_addr,
  input  logic [itree_feat_w(NUM_FEAT)-1:0]   cfg_feat,
  input  logic [DATA_W-1:0]                   cfg_thr,
  input  logic                                cfg_leaf
);

  localparam int FEAT_W = itree_feat_w(NUM_FEAT);
  localparam int LEN_W  = itree_len_w(DEPTH);

  itree_state_t                state_q, state_d;
  logic [DEPTH-1:0]            node_q, node_d;
  logic [LEN_W-1:0]            depth_q, depth_d;
  logic [LEN_W-1:0]            lim_q, lim_d;
  logic [LEN_W-1:0]            len_q, len_d;
  logic [NUM_FEAT*DATA_W-1:0]  data_q, data_d;

  logic [FEAT_W-1:0]           rd_feat;
  logic [DATA_W-1:0]           rd_thr;
  logic                        rd_leaf;
  logic [DATA_W-1:0]           feat_val;
  logic                        feat_bad;
  logic [LEN_W-1:0]            depth_inc;
  logic                        cfg_wr;

  // Writes are only taken in IDLE; one landing on the accept edge is
  // visible to the first WALK read because the read port is combinational.
  assign cfg_wr = cfg_we && (state_q == ST_IDLE);

  itree_node_mem #(
    .DATA_W   (DATA_W),
    .NUM_FEAT (NUM_FEAT),
    .DEPTH    (DEPTH)
  ) u_node_mem (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (cfg_wr),
    .wr_addr  (cfg_addr),
    .wr_feat  (cfg_feat),
    .wr_thr   (cfg_thr),
    .wr_leaf  (cfg_leaf),
    .rd_addr  (node_q),
    .rd_feat  (rd_feat),
    .rd_thr   (rd_thr),
    .rd_leaf  (rd_leaf)
  );

  // Feature mux over the captured sample; an index past NUM_FEAT selects
  // nothing and is turned into a stop by feat_bad.
  always_comb begin
    feat_val = '0;
    for (int f = 0; f < NUM_FEAT; f++) begin
      if (rd_feat == FEAT_W'(f)) begin
        feat_val = data_q[f*DATA_W +: DATA_W];
      end
    end
  end

  assign feat_bad  = int'(rd_feat) >= NUM_FEAT;
  assign depth_inc = depth_q + LEN_W'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      node_q  <= '0;
      depth_q <= '0;
      lim_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      node_q  <= node_d;
      depth_q <= depth_d;
      lim_q   <= lim_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    node_d  = node_q;
    depth_d = depth_q;
    lim_d   = lim_q;
    len_d   = len_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          lim_d   = anom_len;
          node_d  = '0;
          depth_d = '0;
          state_d = ST_WALK;
        end
      end
      ST_WALK: begin
        if (rd_leaf || feat_bad) begin
          len_d   = depth_q;
          state_d = ST_DONE;
        end else begin
          depth_d = depth_inc;
          if (depth_inc == LEN_W'(DEPTH)) begin
            // Bottom of the table reached: stop without another node read.
            len_d   = LEN_W'(DEPTH);
            state_d = ST_DONE;
          end else begin
            // Child index 2i+1 (less-than) or 2i+2 (greater or equal).
            node_d = node_q + node_q +
                     ((feat_val < rd_thr) ? DEPTH'(1) : DEPTH'(2));
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready     = (state_q == ST_IDLE);
  assign out_valid    = (state_q == ST_DONE);
  assign out_path_len = len_q;
  assign out_anomaly  = out_valid && (len_q < lim_q);

`ifdef ITREE_STATS_EN
  logic [15:0] anom_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      anom_cnt_q <= '0;
    end else if (out_valid && out_ready && out_anomaly && (anom_cnt_q != 16'hFFFF)) begin
      anom_cnt_q <= anom_cnt_q + 16'd1;
    end
  end

  assign anom_count = anom_cnt_q;
`endif

endmodule
